// File: rtl/boot_rom_loader.sv
// Boot-time ROM-to-RAM copier. It stalls the core while it streams WORD_COUNT words from a
// synchronous ROM into RAM, then hands the RAM bus transparently to the memory controller.
module boot_rom_loader #(
  parameter int          ROM_ADDR_WIDTH = 8,
  parameter int          WORD_COUNT     = 256,
  parameter logic [31:0] RAM_BASE       = 32'h0000_0000
) (
  input  logic                      CoreClock,
  input  logic                      Reset,
  input  logic                      Reload,
  output logic [ROM_ADDR_WIDTH-1:0] RomAddr,
  input  logic [31:0]               RomData,
  input  logic [31:0]               CtrlAddress,
  input  logic [31:0]               CtrlWriteData,
  input  logic                      CtrlWriteAssert,
  output logic [31:0]               AddressBus,
  output logic [31:0]               DataWriteBus,
  output logic                      WriteAssert,
  output logic                      CpuHold,
  output logic                      BootDone,
  output logic [31:0]               Checksum,
  output logic [1:0]                DbgState
);

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_COPY  = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [ROM_ADDR_WIDTH:0] LAST_IDX = (ROM_ADDR_WIDTH+1)'(WORD_COUNT - 1);

  state_e                    state_q;
  logic [ROM_ADDR_WIDTH-1:0] rom_addr_q;
  logic [ROM_ADDR_WIDTH:0]   index_q;
  logic [31:0]               checksum_q;
  logic                      cpu_hold_q;
  logic                      boot_done_q;

  // Hold/done are registered alongside the state so they always track it exactly.
  always_ff @(posedge CoreClock) begin
    if (Reset) begin
      state_q     <= ST_PRIME;
      rom_addr_q  <= '0;
      index_q     <= '0;
      checksum_q  <= '0;
      cpu_hold_q  <= 1'b1;
      boot_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_PRIME: begin
          state_q    <= ST_COPY;
          rom_addr_q <= rom_addr_q + 1'b1;
        end
        ST_COPY: begin
          index_q    <= index_q + 1'b1;
          rom_addr_q <= rom_addr_q + 1'b1;
          checksum_q <= checksum_q + RomData;
          if (index_q == LAST_IDX) begin
            state_q     <= ST_DONE;
            cpu_hold_q  <= 1'b0;
            boot_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (Reload) begin
            state_q     <= ST_PRIME;
            rom_addr_q  <= '0;
            index_q     <= '0;
            checksum_q  <= '0;
            cpu_hold_q  <= 1'b1;
            boot_done_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_PRIME;
          rom_addr_q  <= '0;
          index_q     <= '0;
          checksum_q  <= '0;
          cpu_hold_q  <= 1'b1;
          boot_done_q <= 1'b0;
        end
      endcase
    end
  end

  // RAM bus mux: the controller only reaches RAM once the image is loaded.
  always_comb begin
    AddressBus   = RAM_BASE;
    DataWriteBus = '0;
    WriteAssert  = 1'b0;
    case (state_q)
      ST_COPY: begin
        AddressBus   = RAM_BASE + 32'(index_q);
        DataWriteBus = RomData;
        WriteAssert  = 1'b1;
      end
      ST_DONE: begin
        AddressBus   = CtrlAddress;
        DataWriteBus = CtrlWriteData;
        WriteAssert  = CtrlWriteAssert;
      end
      default: ;
    endcase
  end

  assign RomAddr  = rom_addr_q;
  assign Checksum = checksum_q;
  assign CpuHold  = cpu_hold_q;
  assign BootDone = boot_done_q;
  assign DbgState = state_q;

endmodule

// File: tb/tb_boot_rom_loader.sv
// Directed bench for boot_rom_loader: a 4-word image into RAM base 0, plus a second
// instance with a 2-bit ROM address and RAM base near the top of the address space.
module tb_boot_rom_loader;

  logic        clk;
  logic        rst;
  logic        reload;
  logic [31:0] ctrl_addr;
  logic [31:0] ctrl_wdata;
  logic        ctrl_we;

  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic [31:0] addr_bus;
  logic [31:0] data_bus;
  logic        we;
  logic        cpu_hold;
  logic        boot_done;
  logic [31:0] csum;
  logic [1:0]  dbg_state;

  logic [1:0]  w_rom_addr;
  logic [31:0] w_rom_data;
  logic [31:0] w_addr_bus;
  logic [31:0] w_data_bus;
  logic        w_we;
  logic        w_cpu_hold;
  logic        w_boot_done;
  logic [31:0] w_csum;
  logic [1:0]  w_dbg_state;

  int total = 0;
  int bad   = 0;

  boot_rom_loader #(.ROM_ADDR_WIDTH(8), .WORD_COUNT(4), .RAM_BASE(32'h0000_0000)) dut (
    .CoreClock(clk), .Reset(rst), .Reload(reload),
    .RomAddr(rom_addr), .RomData(rom_data),
    .CtrlAddress(ctrl_addr), .CtrlWriteData(ctrl_wdata), .CtrlWriteAssert(ctrl_we),
    .AddressBus(addr_bus), .DataWriteBus(data_bus), .WriteAssert(we),
    .CpuHold(cpu_hold), .BootDone(boot_done), .Checksum(csum), .DbgState(dbg_state)
  );

  boot_rom_loader #(.ROM_ADDR_WIDTH(2), .WORD_COUNT(4), .RAM_BASE(32'hFFFF_FFFE)) dut_w (
    .CoreClock(clk), .Reset(rst), .Reload(reload),
    .RomAddr(w_rom_addr), .RomData(w_rom_data),
    .CtrlAddress(ctrl_addr), .CtrlWriteData(ctrl_wdata), .CtrlWriteAssert(ctrl_we),
    .AddressBus(w_addr_bus), .DataWriteBus(w_data_bus), .WriteAssert(w_we),
    .CpuHold(w_cpu_hold), .BootDone(w_boot_done), .Checksum(w_csum), .DbgState(w_dbg_state)
  );

  // Clock and synchronous ROM models: rom[i] = A5000000 + i, one cycle read latency.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    rom_data   <= 32'hA500_0000 + 32'(rom_addr);
    w_rom_data <= 32'hA500_0000 + 32'(w_rom_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks main-instance COPY cycle k (1-based); exp_sum is the sum of the words before it.
  task automatic chk_copy(input int k, input logic [31:0] exp_sum);
    chk($sformatf("copy%0d_we", k),   32'(we),        32'd1);
    chk($sformatf("copy%0d_addr", k), addr_bus,       32'(k - 1));
    chk($sformatf("copy%0d_data", k), data_bus,       32'hA500_0000 + 32'(k - 1));
    chk($sformatf("copy%0d_rom", k),  32'(rom_addr),  32'(k));
    chk($sformatf("copy%0d_hold", k), 32'(cpu_hold),  32'd1);
    chk($sformatf("copy%0d_done", k), 32'(boot_done), 32'd0);
    chk($sformatf("copy%0d_csum", k), csum,           exp_sum);
  endtask

  task automatic chk_prime(input string tag);
    chk({tag, "_we"},   32'(we),        32'd0);
    chk({tag, "_rom"},  32'(rom_addr),  32'd0);
    chk({tag, "_addr"}, addr_bus,       32'd0);
    chk({tag, "_data"}, data_bus,       32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold),  32'd1);
    chk({tag, "_done"}, 32'(boot_done), 32'd0);
    chk({tag, "_csum"}, csum,           32'd0);
  endtask

  task automatic chk_done(input string tag);
    chk({tag, "_done"}, 32'(boot_done), 32'd1);
    chk({tag, "_hold"}, 32'(cpu_hold),  32'd0);
    chk({tag, "_csum"}, csum,           32'h9400_0006);
    chk({tag, "_rom"},  32'(rom_addr),  32'd5);
    chk({tag, "_addr"}, addr_bus,       32'h0000_0010);
    chk({tag, "_data"}, data_bus,       32'hDEAD_BEEF);
    chk({tag, "_we"},   32'(we),        32'd1);
  endtask

  initial begin
    logic [31:0] sum;
    logic [31:0] w_exp_addr [4];
    logic [1:0]  w_exp_rom  [4];
    w_exp_addr = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    w_exp_rom  = '{2'd1, 2'd2, 2'd3, 2'd0};

    // Controller drives a write the whole time; it must only reach RAM in DONE.
    rst = 1'b1; reload = 1'b0;
    ctrl_addr = 32'h10; ctrl_wdata = 32'hDEAD_BEEF; ctrl_we = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // First load
    chk_prime("p0");
    chk("w_p0_rom",  32'(w_rom_addr), 32'd0);
    chk("w_p0_addr", w_addr_bus,      32'hFFFF_FFFE);
    chk("w_p0_we",   32'(w_we),       32'd0);
    sum = '0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_copy(k, sum);
      sum = sum + 32'hA500_0000 + 32'(k - 1);
      chk($sformatf("w_copy%0d_addr", k), w_addr_bus,      w_exp_addr[k-1]);
      chk($sformatf("w_copy%0d_data", k), w_data_bus,      32'hA500_0000 + 32'(k - 1));
      chk($sformatf("w_copy%0d_rom", k),  32'(w_rom_addr), 32'(w_exp_rom[k-1]));
      chk($sformatf("w_copy%0d_we", k),   32'(w_we),       32'd1);
    end
    tick();
    chk_done("d1");
    chk("w_d1_done", 32'(w_boot_done), 32'd1);
    chk("w_d1_csum", w_csum,           32'h9400_0006);
    chk("w_d1_rom",  32'(w_rom_addr),  32'd1);

    // Reload in DONE with a concurrent controller write
    reload = 1'b1;
    #1;
    chk("rl_pass_addr", addr_bus,       32'h0000_0010);
    chk("rl_pass_data", data_bus,       32'hDEAD_BEEF);
    chk("rl_pass_we",   32'(we),        32'd1);
    chk("rl_pass_done", 32'(boot_done), 32'd1);
    tick();
    reload = 1'b0;
    #1;
    chk_prime("p1");

    // Reload pulsed mid-COPY is ignored; DONE arrives exactly at cycle 5
    sum = '0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      reload = (k == 2);
      #1;
      chk_copy(k, sum);
      sum = sum + 32'hA500_0000 + 32'(k - 1);
    end
    reload = 1'b0;
    tick();
    chk_done("d2");

    // Reset asserted at COPY k=2 restarts the load from word 0
    reload = 1'b1;
    tick();
    reload = 1'b0;
    #1;
    chk_prime("p2");
    tick();
    chk_copy(1, 32'h0);
    tick();
    chk_copy(2, 32'hA500_0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk_prime("p3");
    sum = '0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_copy(k, sum);
      sum = sum + 32'hA500_0000 + 32'(k - 1);
    end
    tick();
    chk_done("d3");

    // Controller write deasserted in DONE passes straight through
    ctrl_we = 1'b0; ctrl_addr = 32'h0000_0024; ctrl_wdata = 32'h1234_5678;
    #1;
    chk("d3_idle_we",   32'(we), 32'd0);
    chk("d3_idle_addr", addr_bus, 32'h0000_0024);
    chk("d3_idle_data", data_bus, 32'h1234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
